// File: rtl/wb_regfile.sv
// wb_regfile: MIPS write-back select, 32-entry register file with bypassed reads and a handshaked register dump
module wb_regfile #(
  parameter int INST_SZ  = 32,
  parameter int NUM_REGS = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_reg_write,
  input  logic               i_mem_to_reg,
  input  logic               i_bds_sel,
  input  logic               i_halt,
  input  logic [INST_SZ-1:0] i_read_data,
  input  logic [INST_SZ-1:0] i_alu_result,
  input  logic [INST_SZ-1:0] i_bds,
  input  logic [4:0]         i_write_register,
  input  logic [4:0]         i_rs_addr,
  input  logic [4:0]         i_rt_addr,
  output logic [INST_SZ-1:0] o_rs_data,
  output logic [INST_SZ-1:0] o_rt_data,
  output logic [INST_SZ-1:0] o_wb_data,
  output logic               o_halted,
  output logic               o_stall,
  input  logic               i_dump_req,
  output logic               o_dump_valid,
  input  logic               i_dump_ready,
  output logic [4:0]         o_dump_addr,
  output logic [INST_SZ-1:0] o_dump_data,
  output logic               o_dump_last,
  output logic               o_dump_done
);
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  localparam logic [4:0] LAST = 5'(NUM_REGS - 1);
  state_t state, state_nx;
  logic [INST_SZ-1:0] regs [NUM_REGS];
  logic [4:0] idx;
  logic halted, we, hs, at_last;
  assign o_wb_data = i_bds_sel ? i_bds : i_mem_to_reg ? i_read_data : i_alu_result;
  assign we = i_reg_write && i_write_register != 5'd0 && !halted && state == IDLE;
  assign hs = state == SEND && i_dump_ready;
  assign at_last = idx == LAST;
  assign o_halted = halted;
  // read ports see the write landing this cycle
  always_comb begin
    o_rs_data = (we && i_rs_addr == i_write_register) ? o_wb_data : regs[i_rs_addr];
    o_rt_data = (we && i_rt_addr == i_write_register) ? o_wb_data : regs[i_rt_addr];
  end
  // register array; r0 is never written so it stays 0 from reset
  always_ff @(posedge i_clk) begin
    if (i_reset) for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    else if (we) regs[i_write_register] <= o_wb_data;
  end
  // sticky halt flag, cleared only by reset
  always_ff @(posedge i_clk) begin
    if (i_reset) halted <= 1'b0;
    else if (i_halt) halted <= 1'b1;
  end
  // dump FSM state register
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else state <= state_nx;
  end
  // auto dump fires only on the edge that first sets the halt flag
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = ((i_halt && !halted) || i_dump_req) ? SEND : IDLE;
    else if (state == SEND) state_nx = (hs && at_last) ? DONE : SEND;
    else state_nx = IDLE;
  end
  // dump index wraps to 0 after the last word so the next dump starts clean
  always_ff @(posedge i_clk) begin
    if (i_reset) idx <= '0;
    else if (hs) idx <= at_last ? 5'd0 : idx + 5'd1;
  end
  // dump handshake and stall outputs
  always_comb begin
    o_dump_valid = state == SEND;
    o_dump_last  = state == SEND && at_last;
    o_dump_done  = state == DONE;
    o_stall      = state != IDLE;
    o_dump_addr  = idx;
    o_dump_data  = regs[idx];
  end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed self-checking bench for wb_regfile
module tb_wb_regfile;
  logic clk = 0, rst = 1;
  logic reg_write = 0, mem_to_reg = 0, bds_sel = 0, halt = 0, dump_req = 0, dump_ready = 0;
  logic [31:0] read_data = 0, alu_result = 0, bds = 0;
  logic [4:0] write_register = 0, rs_addr = 0, rt_addr = 0;
  logic [31:0] rs_data, rt_data, wb_data, dump_data;
  logic halted, stall, dump_valid, dump_last, dump_done;
  logic [4:0] dump_addr;
  int n_cmp = 0, n_bad = 0;

  wb_regfile dut (
    .i_clk(clk), .i_reset(rst), .i_reg_write(reg_write), .i_mem_to_reg(mem_to_reg),
    .i_bds_sel(bds_sel), .i_halt(halt), .i_read_data(read_data), .i_alu_result(alu_result),
    .i_bds(bds), .i_write_register(write_register), .i_rs_addr(rs_addr), .i_rt_addr(rt_addr),
    .o_rs_data(rs_data), .o_rt_data(rt_data), .o_wb_data(wb_data), .o_halted(halted),
    .o_stall(stall), .i_dump_req(dump_req), .o_dump_valid(dump_valid), .i_dump_ready(dump_ready),
    .o_dump_addr(dump_addr), .o_dump_data(dump_data), .o_dump_last(dump_last), .o_dump_done(dump_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] v);
    reg_write = 1; write_register = r; alu_result = v; mem_to_reg = 0; bds_sel = 0;
    tick();
    reg_write = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    tick(); tick();
    rst = 0; rs_addr = 5; rt_addr = 31;
    #1;
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted got %b want 0", halted); end
    n_cmp++; if (dump_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", dump_valid); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b want 0", stall); end
    n_cmp++; if (dump_done !== 1'b0 || dump_last !== 1'b0) begin n_bad++; $display("FAIL reset_done_last got %b%b want 00", dump_done, dump_last); end
    n_cmp++; if (dump_addr !== 5'd0 || dump_data !== 32'd0) begin n_bad++; $display("FAIL reset_dump got %0d/%h want 0/0", dump_addr, dump_data); end
    n_cmp++; if (rs_data !== 32'd0 || rt_data !== 32'd0) begin n_bad++; $display("FAIL reset_regs got %h/%h want 0/0", rs_data, rt_data); end
  endtask

  task automatic test_select();
    reg_write = 1; write_register = 5; alu_result = 32'h1234; read_data = 32'hCAFE; bds = 32'h40;
    mem_to_reg = 0; bds_sel = 0;
    #1;
    n_cmp++; if (wb_data !== 32'h1234) begin n_bad++; $display("FAIL sel_alu got %h want 1234", wb_data); end
    tick();
    write_register = 6; mem_to_reg = 1;
    #1;
    n_cmp++; if (wb_data !== 32'hCAFE) begin n_bad++; $display("FAIL sel_load got %h want cafe", wb_data); end
    tick();
    write_register = 31; bds_sel = 1;
    #1;
    n_cmp++; if (wb_data !== 32'h40) begin n_bad++; $display("FAIL sel_bds got %h want 40", wb_data); end
    tick();
    reg_write = 0; bds_sel = 0; mem_to_reg = 0; rs_addr = 5; rt_addr = 6;
    #1;
    n_cmp++; if (rs_data !== 32'h1234) begin n_bad++; $display("FAIL read_r5 got %h want 1234", rs_data); end
    n_cmp++; if (rt_data !== 32'hCAFE) begin n_bad++; $display("FAIL read_r6 got %h want cafe", rt_data); end
    rs_addr = 31;
    #1;
    n_cmp++; if (rs_data !== 32'h40) begin n_bad++; $display("FAIL read_r31 got %h want 40", rs_data); end
  endtask

  task automatic test_r0_bypass();
    reg_write = 1; write_register = 0; alu_result = 32'hFFFF_FFFF; rs_addr = 0;
    #1;
    n_cmp++; if (rs_data !== 32'd0) begin n_bad++; $display("FAIL r0_same got %h want 0", rs_data); end
    tick();
    reg_write = 0;
    #1;
    n_cmp++; if (rs_data !== 32'd0) begin n_bad++; $display("FAIL r0_after got %h want 0", rs_data); end
    reg_write = 1; write_register = 7; alu_result = 32'hAA; rs_addr = 7; rt_addr = 7;
    #1;
    n_cmp++; if (rs_data !== 32'hAA) begin n_bad++; $display("FAIL bypass_rs got %h want aa", rs_data); end
    n_cmp++; if (rt_data !== 32'hAA) begin n_bad++; $display("FAIL bypass_rt got %h want aa", rt_data); end
    tick();
    reg_write = 0;
    #1;
    n_cmp++; if (rs_data !== 32'hAA) begin n_bad++; $display("FAIL r7_stored got %h want aa", rs_data); end
  endtask

  task automatic test_dump_full();
    for (int i = 1; i < 32; i++) wr(5'(i), 32'h100 + 32'(i));
    dump_ready = 1; dump_req = 1;
    tick();
    dump_req = 0;
    for (int k = 0; k < 32; k++) begin
      #1;
      n_cmp++;
      if (dump_valid !== 1'b1 || stall !== 1'b1 || dump_addr !== 5'(k) ||
          dump_data !== (k == 0 ? 32'd0 : 32'h100 + 32'(k)) || dump_last !== (k == 31) || dump_done !== 1'b0) begin
        n_bad++;
        $display("FAIL dump_word%0d got v%b s%b a%0d d%h l%b dn%b want v1 s1 a%0d l%b dn0",
                 k, dump_valid, stall, dump_addr, dump_data, dump_last, dump_done, k, k == 31);
      end
      tick();
    end
    #1;
    n_cmp++; if (dump_done !== 1'b1 || dump_valid !== 1'b0 || stall !== 1'b1) begin n_bad++; $display("FAIL dump_done got dn%b v%b s%b want 1 0 1", dump_done, dump_valid, stall); end
    tick();
    #1;
    n_cmp++; if (dump_done !== 1'b0 || stall !== 1'b0) begin n_bad++; $display("FAIL dump_idle got dn%b s%b want 0 0", dump_done, stall); end
  endtask

  task automatic finish_dump(input string tag);
    int budget = 64;
    dump_ready = 1;
    while (dump_done !== 1'b1 && budget > 0) begin tick(); budget--; end
    n_cmp++; if (dump_done !== 1'b1) begin n_bad++; $display("FAIL %s_timeout got done=%b want 1", tag, dump_done); end
    tick();
  endtask

  task automatic test_dump_ready();
    dump_ready = 1; dump_req = 1;
    tick();
    dump_req = 0;
    #1;
    n_cmp++; if (dump_addr !== 5'd0 || dump_valid !== 1'b1) begin n_bad++; $display("FAIL rdy_w0 got a%0d v%b want 0 1", dump_addr, dump_valid); end
    tick();
    dump_ready = 0;
    #1;
    n_cmp++; if (dump_addr !== 5'd1 || dump_data !== 32'h101) begin n_bad++; $display("FAIL rdy_hold1 got %0d/%h want 1/101", dump_addr, dump_data); end
    reg_write = 1; write_register = 1; alu_result = 32'hDEAD;
    tick();
    reg_write = 0;
    #1;
    n_cmp++; if (dump_addr !== 5'd1 || dump_data !== 32'h101 || dump_valid !== 1'b1) begin n_bad++; $display("FAIL rdy_hold2 got %0d/%h v%b want 1/101 v1", dump_addr, dump_data, dump_valid); end
    tick();
    dump_ready = 1;
    #1;
    n_cmp++; if (dump_addr !== 5'd1 || dump_data !== 32'h101) begin n_bad++; $display("FAIL rdy_resume got %0d/%h want 1/101", dump_addr, dump_data); end
    tick();
    #1;
    n_cmp++; if (dump_addr !== 5'd2 || dump_data !== 32'h102) begin n_bad++; $display("FAIL rdy_adv got %0d/%h want 2/102", dump_addr, dump_data); end
    finish_dump("rdy");
  endtask

  task automatic test_halt();
    reg_write = 1; write_register = 3; alu_result = 32'h55; halt = 1;
    tick();
    reg_write = 0; halt = 0; rs_addr = 3; dump_ready = 1;
    #1;
    n_cmp++; if (halted !== 1'b1 || dump_valid !== 1'b1 || stall !== 1'b1 || dump_addr !== 5'd0) begin n_bad++; $display("FAIL halt_start got h%b v%b s%b a%0d want 1 1 1 0", halted, dump_valid, stall, dump_addr); end
    n_cmp++; if (rs_data !== 32'h55) begin n_bad++; $display("FAIL halt_r3 got %h want 55", rs_data); end
    finish_dump("halt");
    reg_write = 1; write_register = 3; alu_result = 32'h66; halt = 1;
    tick();
    reg_write = 0; halt = 0;
    #1;
    n_cmp++; if (rs_data !== 32'h55) begin n_bad++; $display("FAIL halt_block got %h want 55", rs_data); end
    n_cmp++; if (dump_valid !== 1'b0 || stall !== 1'b0) begin n_bad++; $display("FAIL halt_once got v%b s%b want 0 0", dump_valid, stall); end
  endtask

  task automatic test_reset_mid_dump();
    dump_ready = 1; dump_req = 1;
    tick();
    dump_req = 0;
    repeat (10) tick();
    #1;
    n_cmp++; if (dump_addr !== 5'd10 || dump_data !== 32'h10A) begin n_bad++; $display("FAIL mid_addr got %0d/%h want 10/10a", dump_addr, dump_data); end
    rst = 1;
    tick();
    rst = 0; rs_addr = 3;
    #1;
    n_cmp++; if (dump_valid !== 1'b0 || stall !== 1'b0 || halted !== 1'b0 || dump_done !== 1'b0) begin n_bad++; $display("FAIL mid_reset got v%b s%b h%b dn%b want 0 0 0 0", dump_valid, stall, halted, dump_done); end
    n_cmp++; if (rs_data !== 32'd0 || dump_addr !== 5'd0) begin n_bad++; $display("FAIL mid_regs got r3=%h a%0d want 0 0", rs_data, dump_addr); end
  endtask

  initial begin
    test_reset();
    test_select();
    test_r0_bypass();
    test_dump_full();
    test_dump_ready();
    test_halt();
    test_reset_mid_dump();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and general-purpose register file of the MIPS pipeline. It consumes the MEM/WB register outputs, selects the write-back value, and writes the 32-entry register file. It serves the two decode-stage read ports with same-cycle write bypass. On a halt reaching write-back, or on a debug request, it streams all registers to the debug unit over a valid/ready handshake, stalling the pipeline while it does so.

## Interface
- INST_SZ, 32, data/register width
- NUM_REGS, 32, register count (address width fixed at 5)

- i_clk  in  1  clock, all state updates on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_reg_write  in  1  RegWrite from MEM/WB
- i_mem_to_reg  in  1  MemToReg from MEM/WB
- i_bds_sel  in  1  BDSSel from MEM/WB
- i_halt  in  1  halt instruction has reached write-back
- i_read_data  in  INST_SZ  memory load data
- i_alu_result  in  INST_SZ  ALU result
- i_bds  in  INST_SZ  return address (branch-delay-slot link value)
- i_write_register  in  5  destination register
- i_rs_addr, i_rt_addr  in  5 each  decode read addresses
- o_rs_data, o_rt_data  out  INST_SZ each  decode read data (combinational)
- o_wb_data  out  INST_SZ  selected write-back value (to forwarding unit)
- o_halted  out  1  sticky: halt has retired
- o_stall  out  1  pipeline must hold (dump in progress)
- i_dump_req  in  1  debug request to dump registers
- o_dump_valid  out  1  dump word valid
- i_dump_ready  in  1  debug unit accepts word
- o_dump_addr  out  5  register index of current word
- o_dump_data  out  INST_SZ  register contents
- o_dump_last  out  1  current word is index NUM_REGS-1
- o_dump_done  out  1  one-cycle pulse after last word accepted

## Operation
- Write-back select: i_bds_sel=1 selects i_bds; otherwise i_mem_to_reg=1 selects i_read_data; otherwise i_alu_result. o_wb_data always reflects this select.
- Write enable: we = i_reg_write && i_write_register!=0 && !o_halted && !o_stall.
- Register 0 is never written and always reads 0.
- Read ports: if we && addr==i_write_register, output o_wb_data (bypass); else regs[addr].
- Halt: i_halt=1 at an edge sets o_halted. A write presented in that same cycle is still performed, since o_halted is still 0. Only reset clears o_halted; all later writes are ignored.
- FSM states:
  - IDLE -> SEND on the edge where i_halt rises o_halted (auto dump), or on i_dump_req=1. In SEND the index is 0.
  - SEND: o_dump_valid=1, o_dump_addr=idx, o_dump_data=regs[idx]. On valid&&ready, idx increments. On the handshake at idx=NUM_REGS-1, SEND -> DONE.
  - DONE: o_dump_done=1 for one cycle, then IDLE.
- i_dump_req is ignored outside IDLE. The auto dump triggers only once, on the halt edge.
- o_stall=1 in SEND and DONE. Writes are blocked there, so dump data is stable while valid waits for ready.

## Timing
- Reset values:
  - All registers 0.
  - o_halted=0, FSM IDLE, idx 0.
  - o_dump_valid=0, o_dump_done=0, o_dump_last=0, o_stall=0.
  - o_dump_addr=0. o_dump_data=regs[0]=0.
  - o_rs_data/o_rt_data/o_wb_data follow the combinational rules above.
- Write latency: the value is visible on the read ports in the same cycle via bypass, and from regs[] after the edge.
- Dump request or halt sampled at edge N: o_dump_valid=1 and o_stall=1 from cycle N+1, addr 0.
- With i_dump_ready held at 1, one word per cycle. The last word is in cycle N+32, the o_dump_done pulse in cycle N+33, and IDLE (o_stall=0) from N+34.
- While ready=0, valid/addr/data are held unchanged.
- Reset mid-dump: at the next edge, return to IDLE and clear everything per the reset values. No o_dump_done pulse.

## Test plan
- Write r5 from ALU 0x1234 (mem_to_reg=0, bds_sel=0), then r6 from load 0xCAFE, then r31 from bds 0x40 with mem_to_reg=1 also set -> reads give r5=0x1234, r6=0xCAFE, r31=0x40 (bds wins).
- reg_write to r0 with 0xFFFF_FFFF -> rs_addr=0 reads 0. Bypass case: write r7=0xAA while rs_addr=7 in the same cycle -> o_rs_data=0xAA in that cycle.
- Registers hold 0x100+i; assert i_dump_req with ready=1 -> 32 consecutive words, addr 0..31, data 0 then 0x101..0x11F. o_dump_last only on addr 31, o_dump_done one cycle later, o_stall high throughout.
- Dump with ready toggled 1,0,0,1 -> addr advances only on ready=1, and data stays stable across the stalled cycles.
- i_halt with reg_write r3=0x55 in the same cycle -> r3=0x55, o_halted=1, auto dump starts. A later reg_write r3=0x66 is ignored after the dump completes.
- Assert reset in the middle of a dump at addr 10 -> next cycle o_dump_valid=0, o_stall=0, o_halted=0, and r3 reads 0.
